// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular reservation buffer tracking in-order fetch responses
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_instr,
    input  logic            pop,
    input  logic            flush,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   pending
);

    fetch_entry_t entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] fptr;

    // Unfilled entries are always the contiguous run from fptr up to tail,
    // because responses come back in request order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            fptr    <= '0;
            count   <= '0;
            pending <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            fptr    <= '0;
            count   <= '0;
            pending <= '0;
        end else begin
            if (alloc) begin
                entries[tail] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
                tail          <= tail + PW'(1);
            end
            if (fill) begin
                entries[fptr].instr  <= fill_instr;
                entries[fptr].filled <= 1'b1;
                fptr                 <= fptr + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count   <= count + CW'(alloc) - CW'(pop);
            pending <= pending + CW'(alloc) - CW'(fill);
        end
    end

    assign head_valid = (count != '0) && entries[head].filled;
    assign head_pc    = entries[head].pc;
    assign head_instr = entries[head].instr;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - next-PC selection, imem request gating and stale-response dropping
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    input  logic            ifid_ready,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic            fetch_misaligned
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Outstanding drops plus in-flight requests never exceed 2*DEPTH.
    localparam int DW = $clog2(DEPTH) + 2;

    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic [DW-1:0] drop_cnt;
    logic          misaligned;
    logic          drop_stall;
    logic          grant;
    logic          fill;
    logic          pop;
    logic          rv_consumed;

    assign misaligned       = pc_in[1:0] != 2'b00;
    assign drop_stall       = drop_cnt >= DW'(DEPTH);
    assign fetch_misaligned = reset && misaligned;
    assign imem_addr        = pc_in;

    assign imem_req = reset && !redirect_valid && (count < CW'(DEPTH))
                      && !misaligned && !drop_stall;
    assign grant    = imem_req && imem_gnt;
    assign fill     = imem_rvalid && (drop_cnt == '0) && (pending != '0);
    assign pop      = ifid_valid && ifid_ready;

    // A response that has nowhere to go and nothing to drop is ignored.
    assign rv_consumed = imem_rvalid && ((drop_cnt != '0) || (pending != '0));

    always_comb begin
        pc_next = pc_in;
        if (!reset) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (grant) begin
            pc_next = next_seq_pc(pc_in);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= drop_cnt + DW'(pending) - DW'(rv_consumed);
        end else if (imem_rvalid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - DW'(1);
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .alloc      (grant),
        .alloc_pc   (pc_in),
        .fill       (fill),
        .fill_instr (imem_rdata),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_valid (ifid_valid),
        .head_pc    (ifid_pc),
        .head_instr (ifid_instr),
        .count      (count),
        .pending    (pending)
    );

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && (drop_cnt == '0) && (pending == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        fetch_misaligned;

    int          total  = 0;
    int          bad    = 0;
    int          grants = 0;
    bit          resp_en;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_in            (pc_in),
        .pc_next          (pc_next),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .ifid_valid       (ifid_valid),
        .ifid_ready       (ifid_ready),
        .ifid_instr       (ifid_instr),
        .ifid_pc          (ifid_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    task automatic drive_resp();
        imem_rvalid = resp_en && (q.size() != 0);
        imem_rdata  = imem_rvalid ? instr_of(q[0]) : 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: the bench plays PC register and in-order 1-cycle memory.
    task automatic tick();
        logic        g;
        logic        rv;
        logic [31:0] a;
        logic [31:0] nx;
        g  = imem_req & imem_gnt;
        rv = imem_rvalid;
        a  = imem_addr;
        nx = pc_next;
        @(posedge clk);
        #1;
        pc_in = nx;
        if (rv && q.size() != 0) q.delete(0);
        if (g) begin
            q.push_back(a);
            grants++;
        end
        drive_resp();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q.delete();
        pc_in = 32'h0;
        drive_resp();
        #1;
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        pc_in          = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b1;
        ifid_ready     = 1'b1;
        resp_en        = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        #2;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_mis",   32'(fetch_misaligned), 32'd0);
        chk("rst_pcnext", pc_next, 32'h0);
        chk("rst_ifpc",  ifid_pc, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);

        // streaming from RESET_PC
        tick();
        reset = 1'b1;
        #1;
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_pcnext", pc_next, 32'h4);
        tick();
        chk("t1_nvalid", 32'(ifid_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_valid", 32'(ifid_valid), 32'd1);
            chk("t1_pc", ifid_pc, 32'(4 * i));
            chk("t1_instr", ifid_instr, instr_of(32'(4 * i)));
        end

        // decode stalled: buffer fills to DEPTH
        ifid_ready = 1'b0;
        do_reset();
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 1) begin
                chk("t2_stable_pc", ifid_pc, 32'h0);
                chk("t2_stable_instr", ifid_instr, instr_of(32'h0));
            end
        end
        chk("t2_grants", 32'(grants), 32'd4);
        chk("t2_req", 32'(imem_req), 32'd0);
        chk("t2_pcnext", pc_next, 32'h10);
        chk("t2_valid", 32'(ifid_valid), 32'd1);
        ifid_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_pc", ifid_pc, 32'(4 * i));
            tick();
        end

        // redirect with two requests in flight
        resp_en  = 1'b0;
        imem_gnt = 1'b1;
        do_reset();
        tick();
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3_req", 32'(imem_req), 32'd0);
        chk("t3_pcnext", pc_next, 32'h100);
        tick();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b1;
        resp_en        = 1'b1;
        drive_resp();
        #1;
        chk("t3_drop", 32'(dut.drop_cnt), 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("t3_nostale", 32'(ifid_valid), 32'd0);
            tick();
        end
        chk("t3_valid", 32'(ifid_valid), 32'd1);
        chk("t3_pc", ifid_pc, 32'h100);
        chk("t3_instr", ifid_instr, instr_of(32'h100));

        // redirect coincident with a response, one more in flight
        resp_en  = 1'b0;
        imem_gnt = 1'b1;
        do_reset();
        tick();
        tick();
        imem_gnt       = 1'b0;
        resp_en        = 1'b1;
        drive_resp();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        tick();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b1;
        #1;
        chk("t4_drop1", 32'(dut.drop_cnt), 32'd1);
        chk("t4_nvalid_a", 32'(ifid_valid), 32'd0);
        tick();
        chk("t4_drop0", 32'(dut.drop_cnt), 32'd0);
        chk("t4_nvalid_b", 32'(ifid_valid), 32'd0);
        tick();
        chk("t4_valid", 32'(ifid_valid), 32'd1);
        chk("t4_pc", ifid_pc, 32'h200);
        chk("t4_instr", ifid_instr, instr_of(32'h200));

        // misaligned redirect target stalls fetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        do_reset();
        chk("t5_req_redir", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_mis", 32'(fetch_misaligned), 32'd1);
        chk("t5_pcnext", pc_next, 32'h102);
        for (int i = 0; i < 3; i++) begin
            chk("t5_noreq", 32'(imem_req), 32'd0);
            chk("t5_novalid", 32'(ifid_valid), 32'd0);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_mis_clr", 32'(fetch_misaligned), 32'd0);
        chk("t5_req", 32'(imem_req), 32'd1);
        tick();
        tick();
        chk("t5_valid", 32'(ifid_valid), 32'd1);
        chk("t5_pc", ifid_pc, 32'h200);

        // asynchronous reset pulse mid-stream
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        q.delete();
        pc_in = 32'h0;
        drive_resp();
        #1;
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_valid", 32'(ifid_valid), 32'd0);
        chk("t6_mis", 32'(fetch_misaligned), 32'd0);
        chk("t6_pcnext", pc_next, 32'h0);
        chk("t6_ifpc", ifid_pc, 32'h0);
        chk("t6_instr", ifid_instr, 32'h0);
        chk("t6_drop", 32'(dut.drop_cnt), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", imem_addr, 32'h0);
        tick();
        tick();
        chk("t6_valid_a", 32'(ifid_valid), 32'd1);
        chk("t6_pc_a", ifid_pc, 32'h0);
        chk("t6_instr_a", ifid_instr, instr_of(32'h0));
        tick();
        chk("t6_pc_b", ifid_pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
